sme_feeder: RTL and testbench

Host-side transmitter for the string-matching engine (SME) character protocol. It buffers one string of up to 32 characters and one pattern of up to 8 characters written by a host. On `start` it serialises them onto `chardata`/`isstring`/`ispattern`, then waits for the engine's `valid`/`match`/`match_index` response. It returns the result to the host, or flags a timeout if no response arrives. It sits between the host/stimulus controller and an SME instance, so repeated pattern queries can be issued against a retained string.

---
 rtl/sme_pkg.sv | 20 ++
 rtl/sme_char_buf.sv | 29 ++
 rtl/sme_feeder.sv | 200 ++++++++++++++++++++
 tb/tb_sme_feeder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sme_pkg.sv
// Shared constants and state encoding for the SME host-side feeder.
package sme_pkg;

  localparam logic [7:0] SPACE  = 8'h20;
  localparam logic [7:0] DOT    = 8'h2E;
  localparam logic [7:0] CARET  = 8'h5E;
  localparam logic [7:0] DOLLAR = 8'h24;

  localparam int unsigned STR_MAX_DEF = 32;
  localparam int unsigned PAT_MAX_DEF = 8;

  typedef enum logic [2:0] {
    StIdle,
    StSendStr,
    StSendPat,
    StWait,
    StReport
  } sme_state_e;

endpackage

// File: rtl/sme_char_buf.sv
// Register-array character buffer: one synchronous write port, one asynchronous
// read port, every entry reset to a fill character.
module sme_char_buf #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3,
  parameter logic [7:0]  FILL  = 8'h20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= FILL;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sme_feeder.sv
// Host-side SME transmitter: serialises buffered string/pattern, then waits for
// the engine's result or a timeout and reports it with a one-cycle done pulse.
module sme_feeder
  import sme_pkg::*;
#(
  parameter int unsigned STR_MAX = STR_MAX_DEF,
  parameter int unsigned PAT_MAX = PAT_MAX_DEF,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_str,
  input  logic       wr_pat,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [5:0] str_len,
  input  logic [3:0] pat_len,
  input  logic       send_str,
  input  logic       start,
  output logic       busy,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_index,
  output logic       done,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       timeout
);

  localparam int unsigned WaitW = $clog2(TIMEOUT);

  sme_state_e       r_state, w_state_d;
  logic [4:0]       r_idx, w_idx_d, w_idx_inc;
  logic [WaitW-1:0] r_wait, w_wait_d;
  logic [5:0]       r_slen, w_slen_d, w_slen_clamp;
  logic [3:0]       r_plen, w_plen_d, w_plen_clamp;
  logic             r_busy, w_busy_d, r_isstring, w_isstring_d, r_ispattern, w_ispattern_d;
  logic             r_done, w_done_d, r_res_match, w_res_match_d, r_timeout, w_timeout_d;
  logic [7:0]       r_chardata, w_chardata_d;
  logic [4:0]       r_res_index, w_res_index_d;
  logic [4:0]       w_str_raddr;
  logic [2:0]       w_pat_raddr;
  logic [7:0]       w_str_rdata, w_pat_rdata;

  sme_char_buf #(.DEPTH(STR_MAX), .AW(5), .FILL(SPACE)) u_str_buf (
    .clk     (clk),
    .reset   (reset),
    .i_we    (wr_str & ~r_busy),
    .i_waddr (wr_addr),
    .i_wdata (wr_data),
    .i_raddr (w_str_raddr),
    .o_rdata (w_str_rdata)
  );

  sme_char_buf #(.DEPTH(PAT_MAX), .AW(3), .FILL(DOT)) u_pat_buf (
    .clk     (clk),
    .reset   (reset),
    .i_we    (wr_pat & ~r_busy),
    .i_waddr (wr_addr[2:0]),
    .i_wdata (wr_data),
    .i_raddr (w_pat_raddr),
    .o_rdata (w_pat_rdata)
  );

  // Read address is the index of the character registered at the next edge.
  assign w_idx_inc    = r_idx + 5'd1;
  assign w_str_raddr  = (r_state == StSendStr) ? w_idx_inc : 5'd0;
  assign w_pat_raddr  = (r_state == StSendPat) ? w_idx_inc[2:0] : 3'd0;
  assign w_slen_clamp = (str_len > 6'(STR_MAX)) ? 6'(STR_MAX) : str_len;
  assign w_plen_clamp = (pat_len == 4'd0) ? 4'd1 :
                        (pat_len > 4'(PAT_MAX)) ? 4'(PAT_MAX) : pat_len;

  always_comb begin
    w_state_d     = r_state;
    w_idx_d       = r_idx;
    w_wait_d      = r_wait;
    w_slen_d      = r_slen;
    w_plen_d      = r_plen;
    w_busy_d      = r_busy;
    w_chardata_d  = 8'h00;
    w_isstring_d  = 1'b0;
    w_ispattern_d = 1'b0;
    w_done_d      = 1'b0;
    w_res_match_d = r_res_match;
    w_res_index_d = r_res_index;
    w_timeout_d   = r_timeout;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_slen_d = w_slen_clamp;
          w_plen_d = w_plen_clamp;
          w_busy_d = 1'b1;
          w_idx_d  = 5'd0;
          if (send_str && w_slen_clamp != 6'd0) begin
            w_state_d    = StSendStr;
            w_chardata_d = w_str_rdata;
            w_isstring_d = 1'b1;
          end else begin
            w_state_d     = StSendPat;
            w_chardata_d  = w_pat_rdata;
            w_ispattern_d = 1'b1;
          end
        end
      end
      StSendStr: begin
        if ({1'b0, r_idx} == r_slen - 6'd1) begin
          w_state_d     = StSendPat;
          w_idx_d       = 5'd0;
          w_chardata_d  = w_pat_rdata;
          w_ispattern_d = 1'b1;
        end else begin
          w_idx_d      = w_idx_inc;
          w_chardata_d = w_str_rdata;
          w_isstring_d = 1'b1;
        end
      end
      StSendPat: begin
        if (r_idx[2:0] == 3'(r_plen - 4'd1)) begin
          w_state_d = StWait;
          w_wait_d  = WaitW'(1);
        end else begin
          w_idx_d       = w_idx_inc;
          w_chardata_d  = w_pat_rdata;
          w_ispattern_d = 1'b1;
        end
      end
      StWait: begin
        // A result arriving on the expiry cycle takes priority over the timeout.
        if (sme_valid) begin
          w_state_d     = StReport;
          w_done_d      = 1'b1;
          w_res_match_d = sme_match;
          w_res_index_d = sme_index;
          w_timeout_d   = 1'b0;
        end else if (r_wait == WaitW'(TIMEOUT - 1)) begin
          w_state_d     = StReport;
          w_done_d      = 1'b1;
          w_res_match_d = 1'b0;
          w_res_index_d = 5'd0;
          w_timeout_d   = 1'b1;
        end else begin
          w_wait_d = r_wait + WaitW'(1);
        end
      end
      StReport: begin
        w_state_d = StIdle;
        w_busy_d  = 1'b0;
      end
      default: begin
        w_state_d = StIdle;
        w_busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_wait      <= '0;
      r_slen      <= '0;
      r_plen      <= '0;
      r_busy      <= 1'b0;
      r_chardata  <= 8'h00;
      r_isstring  <= 1'b0;
      r_ispattern <= 1'b0;
      r_done      <= 1'b0;
      r_res_match <= 1'b0;
      r_res_index <= 5'd0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_idx       <= w_idx_d;
      r_wait      <= w_wait_d;
      r_slen      <= w_slen_d;
      r_plen      <= w_plen_d;
      r_busy      <= w_busy_d;
      r_chardata  <= w_chardata_d;
      r_isstring  <= w_isstring_d;
      r_ispattern <= w_ispattern_d;
      r_done      <= w_done_d;
      r_res_match <= w_res_match_d;
      r_res_index <= w_res_index_d;
      r_timeout   <= w_timeout_d;
    end
  end

  assign busy      = r_busy;
  assign chardata  = r_chardata;
  assign isstring  = r_isstring;
  assign ispattern = r_ispattern;
  assign done      = r_done;
  assign res_match = r_res_match;
  assign res_index = r_res_index;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_sme_feeder.sv
// Directed bench for sme_feeder: string/pattern serialisation, results, timeout,
// busy-time rejection, length clamping and mid-job reset.
module tb_sme_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_str, wr_pat, send_str, start;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic [5:0] str_len;
  logic [3:0] pat_len;
  logic       busy, isstring, ispattern, done, res_match, timeout;
  logic [7:0] chardata;
  logic       sme_valid, sme_match;
  logic [4:0] sme_index, res_index;

  int nvec = 0;
  int nerr = 0;
  int n;

  sme_feeder dut (
    .clk       (clk),
    .reset     (reset),
    .wr_str    (wr_str),
    .wr_pat    (wr_pat),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .str_len   (str_len),
    .pat_len   (pat_len),
    .send_str  (send_str),
    .start     (start),
    .busy      (busy),
    .chardata  (chardata),
    .isstring  (isstring),
    .ispattern (ispattern),
    .sme_valid (sme_valid),
    .sme_match (sme_match),
    .sme_index (sme_index),
    .done      (done),
    .res_match (res_match),
    .res_index (res_index),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wbuf(input string s, input logic to_str);
    for (int i = 0; i < s.len(); i++) begin
      wr_str  = to_str;
      wr_pat  = !to_str;
      wr_addr = 5'(i);
      wr_data = s[i];
      tick();
    end
    wr_str = 1'b0;
    wr_pat = 1'b0;
  endtask

  task automatic go(input logic [5:0] sl, input logic [3:0] pl, input logic ss);
    str_len  = sl;
    pat_len  = pl;
    send_str = ss;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Checks n consecutive character cycles; positions past the text expect the pad byte.
  task automatic phase(input string tag, input string s, input int cnt, input logic is_str,
                       input logic [7:0] pad);
    logic [7:0] e;
    for (int i = 0; i < cnt; i++) begin
      e = (i < s.len()) ? s[i] : pad;
      chk({tag, "_strobe"}, {30'b0, isstring, ispattern}, is_str ? 32'd2 : 32'd1);
      chk({tag, "_char"}, {24'b0, chardata}, {24'b0, e});
      chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
      tick();
    end
  endtask

  task automatic wait_idle(input string tag);
    chk({tag, "_wait_strobes"}, {22'b0, isstring, ispattern, chardata}, 32'd0);
    chk({tag, "_wait_done"}, {31'b0, done}, 32'd0);
  endtask

  task automatic respond(input logic m, input logic [4:0] idx);
    sme_valid = 1'b1;
    sme_match = m;
    sme_index = idx;
    tick();
    sme_valid = 1'b0;
    sme_match = 1'b0;
    sme_index = 5'd0;
  endtask

  initial begin
    reset = 1'b1; wr_str = 0; wr_pat = 0; wr_addr = 0; wr_data = 0;
    str_len = 0; pat_len = 0; send_str = 0; start = 0;
    sme_valid = 0; sme_match = 0; sme_index = 0;
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_strobes", {30'b0, isstring, ispattern}, 32'd0);
    chk("rst_chardata", {24'b0, chardata}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_res", {25'b0, timeout, res_match, res_index}, 32'd0);
    reset = 1'b0;
    tick();

    // Job 1: full string then pattern, match at 10
    wbuf("THIS IS A BOOK", 1'b1);
    wbuf("BOOK", 1'b0);
    go(6'd14, 4'd4, 1'b1);
    phase("j1_str", "THIS IS A BOOK", 14, 1'b1, 8'h20);
    phase("j1_pat", "BOOK", 4, 1'b0, 8'h2E);
    wait_idle("j1");
    tick();
    respond(1'b1, 5'd10);
    chk("j1_done", {31'b0, done}, 32'd1);
    chk("j1_res", {25'b0, timeout, res_match, res_index}, {25'b0, 1'b0, 1'b1, 5'd10});
    chk("j1_busy_at_done", {31'b0, busy}, 32'd1);
    tick();
    chk("j1_after", {30'b0, busy, done}, 32'd0);
    chk("j1_hold", {27'b0, res_index}, 32'd10);

    // Job 2: pattern only; stray valid during pattern phase must be ignored
    wbuf("^TH", 1'b0);
    go(6'd14, 4'd3, 1'b0);
    sme_valid = 1'b1; sme_match = 1'b0; sme_index = 5'd7;
    phase("j2_pat", "^TH", 1, 1'b0, 8'h2E);
    sme_valid = 1'b0; sme_index = 5'd0;
    phase("j2_pat_tail", "TH", 2, 1'b0, 8'h2E);
    wait_idle("j2");
    respond(1'b1, 5'd0);
    chk("j2_done", {31'b0, done}, 32'd1);
    chk("j2_res", {25'b0, timeout, res_match, res_index}, {25'b0, 1'b0, 1'b1, 5'd0});
    tick();

    // Job 3: no response -> timeout; start and string write while busy are dropped
    go(6'd0, 4'd1, 1'b1);
    chk("j3_no_str", {30'b0, isstring, ispattern}, 32'd1);
    chk("j3_char", {24'b0, chardata}, 32'h5E);
    tick();
    start = 1'b1; wr_str = 1'b1; wr_addr = 5'd0; wr_data = 8'h58;
    tick();
    start = 1'b0; wr_str = 1'b0;
    n = 2;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    chk("j3_latency", n, 32'd64);
    chk("j3_res", {25'b0, timeout, res_match, res_index}, {25'b0, 1'b1, 1'b0, 5'd0});
    tick();
    tick();
    chk("j3_no_restart", {29'b0, busy, isstring, ispattern}, 32'd0);

    // Job 4: clamped lengths (40 -> 32, 0 -> 1); byte 0 must still be 'T'
    go(6'd40, 4'd0, 1'b1);
    phase("j4_str", "THIS IS A BOOK", 32, 1'b1, 8'h20);
    phase("j4_pat", "^", 1, 1'b0, 8'h2E);
    wait_idle("j4");
    respond(1'b0, 5'd31);
    chk("j4_res", {25'b0, timeout, res_match, res_index}, {25'b0, 1'b0, 1'b0, 5'd31});
    chk("j4_done", {31'b0, done}, 32'd1);
    tick();

    // Job 5: reset during string phase, then buffers hold reset fill
    go(6'd5, 4'd1, 1'b1);
    tick();
    chk("j5_pre_rst", {31'b0, isstring}, 32'd1);
    reset = 1'b1;
    #1;
    chk("j5_rst_strobes", {29'b0, busy, isstring, ispattern}, 32'd0);
    chk("j5_rst_char", {24'b0, chardata}, 32'd0);
    #2;
    reset = 1'b0;
    tick();
    go(6'd3, 4'd1, 1'b1);
    phase("j5_str", "", 3, 1'b1, 8'h20);
    phase("j5_pat", "", 1, 1'b0, 8'h2E);
    wait_idle("j5");
    respond(1'b1, 5'd2);
    chk("j5_res", {25'b0, timeout, res_match, res_index}, {25'b0, 1'b0, 1'b1, 5'd2});
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
